// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control registers (ID/EX, EX/MEM, MEM/WB).
// Default field widths, bundle layout offsets and the NOP control word.
package pipe_ctrl_pkg;

  localparam int DEF_WB_W  = 2;
  localparam int DEF_MEM_W = 2;
  localparam int DEF_EX_W  = 4;

  localparam int CTRL_W = DEF_WB_W + DEF_MEM_W + DEF_EX_W;

  // Bundle layout: WB in the top bits, then MEM, with EX in the low bits.
  localparam int EX_LSB  = 0;
  localparam int MEM_LSB = DEF_EX_W;
  localparam int WB_LSB  = DEF_EX_W + DEF_MEM_W;

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  function automatic int ctrl_width(input int wb_w, input int mem_w, input int ex_w);
    return wb_w + mem_w + ex_w;
  endfunction

endpackage

// File: rtl/ctrl_bubble_reg_if.sv
// Control-bundle interface between the decode stage and the ID/EX control register.
// The master side is the decoder/hazard unit; the slave side is the register.
interface ctrl_bubble_reg_if
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_W  = DEF_WB_W,
  parameter int MEM_W = DEF_MEM_W,
  parameter int EX_W  = DEF_EX_W,
  parameter int CNT_W = 16
);

  logic [WB_W+MEM_W+EX_W-1:0] control_i;
  logic                       valid_i;
  logic                       bubble_i;
  logic                       stall_i;
  logic                       flush_i;

  logic [WB_W-1:0]            control_WB_o;
  logic [MEM_W-1:0]           control_MEM_o;
  logic [EX_W-1:0]            control_EX_o;
  logic                       valid_o;
  logic                       bubble_pend_o;
  logic [CNT_W-1:0]           bubble_cnt_o;

  modport master (
    output control_i, valid_i, bubble_i, stall_i, flush_i,
    input  control_WB_o, control_MEM_o, control_EX_o, valid_o, bubble_pend_o, bubble_cnt_o
  );

  modport slave (
    input  control_i, valid_i, bubble_i, stall_i, flush_i,
    output control_WB_o, control_MEM_o, control_EX_o, valid_o, bubble_pend_o, bubble_cnt_o
  );

endinterface

// File: rtl/ctrl_bubble_reg_sat_counter.sv
// Saturating up-counter for hazard statistics; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ctrl_bubble_reg.sv
// ID/EX control pipeline register with bubble insertion, stall hold, flush and a
// bubble deferred behind a stall; counts inserted bubbles with a saturating counter.
module ctrl_bubble_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int WB_W  = DEF_WB_W,
  parameter int MEM_W = DEF_MEM_W,
  parameter int EX_W  = DEF_EX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ctrl_bubble_reg_if.slave bus
);

  localparam int CW      = ctrl_width(WB_W, MEM_W, EX_W);
  localparam int F_EX    = 0;
  localparam int F_MEM   = EX_W;
  localparam int F_WB    = EX_W + MEM_W;

  if ((WB_W < 1) || (MEM_W < 1) || (EX_W < 1) || (CNT_W < 1)) begin : g_bad_width
    $error("ctrl_bubble_reg: WB_W, MEM_W, EX_W and CNT_W must all be at least 1");
  end

  logic [CW-1:0]    ctrl;
  logic [WB_W-1:0]  wb_q;
  logic [MEM_W-1:0] mem_q;
  logic [EX_W-1:0]  ex_q;
  logic             valid_q;
  logic             pend_q;
  logic             take_bubble;

  assign ctrl = bus.control_i;

  // A bubble is inserted only on an unstalled, unflushed edge; a pending bubble and a
  // fresh request on the same edge collapse into one NOP.
  assign take_bubble = !bus.flush_i && !bus.stall_i && (bus.bubble_i || pend_q);

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q    <= '0;
      mem_q   <= '0;
      ex_q    <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else if (bus.flush_i) begin
      wb_q    <= '0;
      mem_q   <= '0;
      ex_q    <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else if (bus.stall_i) begin
      if (bus.bubble_i) begin
        pend_q <= 1'b1;
      end
    end else if (take_bubble) begin
      wb_q    <= '0;
      mem_q   <= '0;
      ex_q    <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      wb_q    <= ctrl[F_WB +: WB_W];
      mem_q   <= ctrl[F_MEM +: MEM_W];
      ex_q    <= ctrl[F_EX +: EX_W];
      valid_q <= bus.valid_i;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (take_bubble),
    .cnt_o (bus.bubble_cnt_o)
  );

  assign bus.control_WB_o  = wb_q;
  assign bus.control_MEM_o = mem_q;
  assign bus.control_EX_o  = ex_q;
  assign bus.valid_o       = valid_q;
  assign bus.bubble_pend_o = pend_q;

endmodule
